alu_muldiv_seq: RTL and testbench

Multi-cycle multiply/divide sequencer that sits beside the single-cycle ALU in the execute stage. It accepts one 32-bit multiply or divide request and iterates one shift-add or shift-subtract step per clock. It writes a 64-bit result to HI/LO and reports completion with a one-cycle `done` pulse. The pipeline controller stalls on `busy` and reads `hi`/`lo` after `done`.

---
 rtl/alu_muldiv_seq.sv | 168 ++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle multiply/divide sequencer for the execute stage.
// One shift-add (multiply) or restoring shift-subtract (divide) step per clock;
// the 2*WIDTH-bit result lands in hi/lo and is announced by a one-cycle done pulse.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   start     request strobe, sampled only in the idle state
//   op        bit0: 0 = multiply, 1 = divide; bit1: 0 = unsigned, 1 = signed
//   a, b      multiplicand/dividend and multiplier/divisor, captured on accept
//   busy      high from accept through the fix-up cycle
//   done      one-cycle pulse when hi/lo become valid
//   div_zero  set with done when the divide had b = 0; cleared on next accept
//   hi, lo    multiply: product high/low; divide: remainder/quotient
module alu_muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e            state_q;
  logic              is_div_q;
  logic              neg_lo_q;
  logic              neg_hi_q;
  logic              dz_q;
  logic [CntW-1:0]   cnt_q;
  // acc_hi/acc_lo: multiply accumulator pair, or remainder/quotient when dividing.
  // opnd holds |multiplicand| or |divisor|.
  logic [WIDTH-1:0]  acc_hi_q;
  logic [WIDTH-1:0]  acc_lo_q;
  logic [WIDTH-1:0]  opnd_q;

  // Request decode: sign flags are forced to zero for unsigned requests.
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  always_comb begin
    sa    = op[1] & a[WIDTH-1];
    sb    = op[1] & b[WIDTH-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
  end

  // One iteration step.
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    addend    = acc_lo_q[0] ? opnd_q : {WIDTH{1'b0}};
    mul_sum   = {1'b0, acc_hi_q} + {1'b0, addend};
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    div_ge    = div_shift >= {1'b0, opnd_q};
    if (is_div_q) begin
      // rem < divisor holds every step, so the kept value always fits WIDTH bits.
      step_hi = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up and final result selection.
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_lo_q ? -prod : prod;
    if (dz_q) begin
      // No iterations ran, so acc_lo still holds |a|; re-applying the sign restores a.
      fix_hi = neg_hi_q ? -acc_lo_q : acc_lo_q;
      fix_lo = {WIDTH{1'b1}};
    end else if (is_div_q) begin
      fix_hi = neg_hi_q ? -acc_hi_q : acc_hi_q;
      fix_lo = neg_lo_q ? -acc_lo_q : acc_lo_q;
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            is_div_q <= op[0];
            neg_lo_q <= sa ^ sb;
            neg_hi_q <= op[0] ? sa : (sa ^ sb);
            dz_q     <= op[0] && (b == '0);
            cnt_q    <= '0;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            acc_hi_q <= '0;
            acc_lo_q <= op[0] ? mag_a : mag_b;
            opnd_q   <= op[0] ? mag_b : mag_a;
            // Divide by zero skips the iterations and goes straight to result load.
            state_q  <= (op[0] && (b == '0)) ? StFix : StCalc;
          end
        end
        StCalc: begin
          acc_hi_q <= step_hi;
          acc_lo_q <= step_lo;
          cnt_q    <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          hi       <= fix_hi;
          lo       <= fix_lo;
          div_zero <= dz_q;
          done     <= 1'b1;
          busy     <= 1'b0;
          state_q  <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed corner cases plus randomized
// requests compared against a plain-arithmetic reference model.
module tb_alu_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  alu_muldiv_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {div_zero, hi, lo} from ordinary integer arithmetic.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint      sx;
    longint      sy;
    longint      q;
    longint      r;
    logic [63:0] p;
    if (!o[0]) begin
      if (o[1]) p = longint'($signed(x)) * longint'($signed(y));
      else      p = {32'd0, x} * {32'd0, y};
      return {1'b0, p};
    end
    if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
    if (o[1]) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'd0, x});
      sy = longint'({32'd0, y});
    end
    q = sx / sy;
    r = sx % sy;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Present a request at a negedge; returns one negedge after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; lat counts cycles after the accepting edge.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic check_result(input string tag, input logic [1:0] o, input logic [31:0] x,
                              input logic [31:0] y, input int lat);
    logic [64:0] exp;
    exp = model(o, x, y);
    check({tag, "_lat"}, 64'(lat), (o[0] && y == 32'd0) ? 64'd2 : 64'd34);
    check({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
    check({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
    check({tag, "_dz"}, 64'(div_zero), 64'(exp[64]));
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic run_req(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y);
    int lat;
    issue(o, x, y);
    check({tag, "_busy1"}, 64'(busy), 64'd1);
    check({tag, "_dzclr"}, 64'(div_zero), 64'd0);
    wait_done(1, lat);
    check_result(tag, o, x, y, lat);
  endtask

  initial begin
    int          lat;
    int          n_done;
    int          t_done[$];
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;

    // Directed cases.
    run_req("umul_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_req("smul_neg", 2'b10, 32'hFFFF_FFF9, 32'd6);
    run_req("smul_min", 2'b10, 32'h8000_0000, 32'h8000_0000);
    run_req("udiv", 2'b01, 32'd100, 32'd7);
    run_req("sdiv_neg", 2'b11, 32'hFFFF_FF9C, 32'd7);
    run_req("sdiv_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    run_req("udiv_zero", 2'b01, 32'h0000_1234, 32'd0);
    run_req("after_dz", 2'b00, 32'd3, 32'd5);
    run_req("sdiv_zero", 2'b11, 32'hFFFF_FF00, 32'd0);

    // start held high: one request every 35 cycles.
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    a     = 32'd1234;
    b     = 32'd5678;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      if (done) t_done.push_back(i);
    end
    start = 1'b0;
    n_done = t_done.size();
    check("held_count", 64'(n_done), 64'd3);
    if (n_done == 3) begin
      check("held_first", 64'(t_done[0]), 64'd34);
      check("held_gap1", 64'(t_done[1] - t_done[0]), 64'd35);
      check("held_gap2", 64'(t_done[2] - t_done[1]), 64'd35);
    end
    wait_done(0, lat);
    check_result("held_last", 2'b00, 32'd1234, 32'd5678, 34);

    // start pulsed mid-CALC is ignored and hi/lo stay put while calculating.
    hold_hi = hi;
    hold_lo = lo;
    issue(2'b11, 32'hFFFF_FC18, 32'd13);
    repeat (8) @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    a     = 32'd99;
    b     = 32'd77;
    @(negedge clk);
    start = 1'b0;
    check("mid_hi_stable", 64'(hi), 64'(hold_hi));
    check("mid_lo_stable", 64'(lo), 64'(hold_lo));
    check("mid_busy", 64'(busy), 64'd1);
    wait_done(10, lat);
    check_result("mid_pulse", 2'b11, 32'hFFFF_FC18, 32'd13, lat);
    repeat (2) @(negedge clk);
    check("mid_no_second", 64'(busy), 64'd0);

    // Reset during CALC step 10.
    issue(2'b00, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_hilo", {hi, lo}, 64'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("mrst_quiet", 64'(n_done), 64'd0);
    run_req("post_rst", 2'b10, 32'hFFFF_FFFF, 32'h7FFF_FFFF);

    // Randomized requests.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      run_req("rand", ro, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
